// File: rtl/nonrestoring_div.sv
// nonrestoring_div: multi-cycle signed radix-2 non-restoring divider, quotient truncates toward zero,
// remainder takes the dividend's sign; same vld_in/done handshake as the sequential multiplier.
module nonrestoring_div #(
    parameter int WIDTH_D = 8,
    parameter int WIDTH_V = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               vld_in,
    input  logic [WIDTH_D-1:0] dividend,
    input  logic [WIDTH_V-1:0] divisor,
    output logic [WIDTH_D-1:0] quotient,
    output logic [WIDTH_V-1:0] remainder,
    output logic               done,
    output logic               div_by_zero
);
    localparam int CW = $clog2(WIDTH_D + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, OUTPUT} state_t;

    state_t             state, state_nx;
    logic [WIDTH_D-1:0] q;
    logic [WIDTH_V-1:0] b;
    logic [WIDTH_V:0]   p;
    logic [CW-1:0]      count;
    logic               sign_q, sign_r, dz;
    logic [WIDTH_V:0]   b_ext, p_sh, p_step, p_fix;
    logic [WIDTH_V-1:0] r_mag;

    // One P width is enough: |P| never exceeds |divisor| <= 2^(WIDTH_V-1), so 2P still fits.
    always_comb begin
        b_ext  = {1'b0, b};
        p_sh   = {p[WIDTH_V-1:0], q[WIDTH_D-1]};
        p_step = p[WIDTH_V] ? p_sh + b_ext : p_sh - b_ext;
        p_fix  = p[WIDTH_V] ? p + b_ext : p;
        r_mag  = p_fix[WIDTH_V-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!vld_in) state_nx = IDLE;
        else begin
            case (state)
                IDLE:   state_nx = CALC;
                CALC:   state_nx = (count == CW'(WIDTH_D - 1)) ? FIX : CALC;
                FIX:    state_nx = OUTPUT;
                OUTPUT: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q           <= '0;
            b           <= '0;
            p           <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (vld_in) begin
                case (state)
                    IDLE: begin
                        q      <= dividend[WIDTH_D-1] ? -dividend : dividend;
                        b      <= divisor[WIDTH_V-1] ? -divisor : divisor;
                        sign_q <= dividend[WIDTH_D-1] ^ divisor[WIDTH_V-1];
                        sign_r <= dividend[WIDTH_D-1];
                        dz     <= divisor == '0;
                        p      <= '0;
                        count  <= '0;
                    end
                    CALC: begin
                        p     <= p_step;
                        q     <= {q[WIDTH_D-2:0], ~p_step[WIDTH_V]};
                        count <= count + CW'(1);
                    end
                    FIX: begin
                        quotient    <= dz ? '1 : (sign_q ? -q : q);
                        remainder   <= sign_r ? -r_mag : r_mag;
                        div_by_zero <= dz;
                    end
                    OUTPUT: done <= 1'b1;
                endcase
            end
        end
    end
endmodule
